// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the shared ALU and the result consumer.
// slave is the arbiter side; master is the surrounding environment.
interface alu_arbiter_if;
  logic        r0_valid;
  logic        r1_valid;
  logic        r0_ready;
  logic        r1_ready;
  logic [3:0]  r0_cmd;
  logic [3:0]  r1_cmd;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic        r0_s;
  logic        r1_s;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_c_in;
  logic [31:0] alu_out;
  logic [3:0]  alu_nzcv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_nzcv;
  logic [3:0]  status;

  modport slave (
    input  r0_valid, r1_valid, r0_cmd, r1_cmd, r0_a, r0_b, r1_a, r1_b,
           r0_s, r1_s, alu_out, alu_nzcv, rsp_ready,
    output r0_ready, r1_ready, alu_cmd, alu_in1, alu_in2, alu_c_in,
           rsp_valid, rsp_id, rsp_data, rsp_nzcv, status
  );

  modport master (
    output r0_valid, r1_valid, r0_cmd, r1_cmd, r0_a, r0_b, r1_a, r1_b,
           r0_s, r1_s, alu_out, alu_nzcv, rsp_ready,
    input  r0_ready, r1_ready, alu_cmd, alu_in1, alu_in2, alu_c_in,
           rsp_valid, rsp_id, rsp_data, rsp_nzcv, status
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// one operation in flight, with an architectural NZCV status register.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        id_q;
  logic        s_q;
  logic [3:0]  cmd_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_data_q;
  logic [3:0]  rsp_nzcv_q;
  logic [3:0]  status_q;

  logic        grant_any;
  logic        grant_id;

  // On a tie the requester not served last wins; otherwise the lone valid one.
  assign grant_any = bus.r0_valid | bus.r1_valid;
  assign grant_id  = (bus.r0_valid & bus.r1_valid) ? ~last_grant : bus.r1_valid;

  assign bus.r0_ready  = (state == IDLE) && grant_any && !grant_id;
  assign bus.r1_ready  = (state == IDLE) && grant_any && grant_id;
  assign bus.alu_cmd   = cmd_q;
  assign bus.alu_in1   = a_q;
  assign bus.alu_in2   = b_q;
  assign bus.alu_c_in  = status_q[1];
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_nzcv  = rsp_nzcv_q;
  assign bus.status    = status_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      s_q         <= 1'b0;
      cmd_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_nzcv_q  <= '0;
      status_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            id_q       <= grant_id;
            last_grant <= grant_id;
            cmd_q      <= grant_id ? bus.r1_cmd : bus.r0_cmd;
            a_q        <= grant_id ? bus.r1_a   : bus.r0_a;
            b_q        <= grant_id ? bus.r1_b   : bus.r0_b;
            s_q        <= grant_id ? bus.r1_s   : bus.r0_s;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= bus.alu_out;
          rsp_nzcv_q  <= bus.alu_nzcv;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          if (s_q) status_q <= bus.alu_nzcv;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level
// model; the shared ALU is modelled here as part of the environment.
module tb_alu_arbiter;
  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: 0 AND, 1 OR, 2 ADD, 3 ADDC, 4 SUB, 5 XOR, 6 MOV b, else pass a.
  function automatic logic [35:0] alu_fn(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
    longint unsigned wide;
    logic [31:0] r;
    logic c;
    logic v;
    c = 1'b0;
    v = 1'b0;
    case (cmd)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2, 4'd3: begin
        wide = longint'(a) + longint'(b) + ((cmd == 4'd3) ? longint'(cin) : 0);
        r = wide[31:0];
        c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd4: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd5: r = a ^ b;
      4'd6: r = b;
      default: r = a;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {bus.alu_nzcv, bus.alu_out} = alu_fn(bus.alu_cmd, bus.alu_in1, bus.alu_in2, bus.alu_c_in);

  // Reference model: an operation is either absent or in flight since cycle acc.
  bit          busy;
  int          cyc;
  int          acc;
  int          m_last;
  logic        m_id;
  logic        m_s;
  logic [3:0]  m_cmd;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [31:0] m_data;
  logic [3:0]  m_nzcv;
  logic [3:0]  m_status;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic v0;
    logic v1;
    logic gany;
    logic g;
    logic exp_rv;
    @(negedge clk);
    v0     = bus.r0_valid;
    v1     = bus.r1_valid;
    gany   = v0 | v1;
    g      = (v0 && v1) ? (m_last == 0) : v1;
    exp_rv = busy && (cyc >= acc + 2);
    check("r0_ready", 32'(bus.r0_ready), 32'(!busy && gany && !g));
    check("r1_ready", 32'(bus.r1_ready), 32'(!busy && gany && g));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    check("status", 32'(bus.status), 32'(m_status));
    check("alu_c_in", 32'(bus.alu_c_in), 32'(m_status[1]));
    if (busy) begin
      check("alu_cmd", 32'(bus.alu_cmd), 32'(m_cmd));
      check("alu_in1", bus.alu_in1, m_a);
      check("alu_in2", bus.alu_in2, m_b);
    end
    if (exp_rv) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      check("rsp_data", bus.rsp_data, m_data);
      check("rsp_nzcv", 32'(bus.rsp_nzcv), 32'(m_nzcv));
    end
    if (!busy) begin
      if (gany) begin
        busy   = 1'b1;
        acc    = cyc;
        m_id   = g;
        m_last = int'(g);
        m_cmd  = g ? bus.r1_cmd : bus.r0_cmd;
        m_a    = g ? bus.r1_a : bus.r0_a;
        m_b    = g ? bus.r1_b : bus.r0_b;
        m_s    = g ? bus.r1_s : bus.r0_s;
      end
    end else if (cyc == acc + 1) begin
      {m_nzcv, m_data} = alu_fn(m_cmd, m_a, m_b, m_status[1]);
      if (m_s) m_status = m_nzcv;
    end else if (bus.rsp_ready) begin
      busy = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    busy         = 1'b0;
    m_status     = '0;
    m_last       = 1;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_nzcv", 32'(bus.rsp_nzcv), 32'd0);
    check("rst_status", 32'(bus.status), 32'd0);
    check("rst_alu_cmd", 32'(bus.alu_cmd), 32'd0);
    check("rst_alu_in1", bus.alu_in1, 32'd0);
    check("rst_alu_in2", bus.alu_in2, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  task automatic set_req(input int unsigned n, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
    if (n == 0) begin
      bus.r0_valid = 1'b1; bus.r0_cmd = cmd; bus.r0_a = a; bus.r0_b = b; bus.r0_s = s;
    end else begin
      bus.r1_valid = 1'b1; bus.r1_cmd = cmd; bus.r1_a = a; bus.r1_b = b; bus.r1_s = s;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    acc    = 0;
    rst    = 1'b0;
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    bus.r0_cmd = '0; bus.r1_cmd = '0;
    bus.r0_a = '0; bus.r0_b = '0; bus.r1_a = '0; bus.r1_b = '0;
    bus.r0_s = 1'b0; bus.r1_s = 1'b0;
    bus.rsp_ready = 1'b1;
    m_id = 1'b0; m_s = 1'b0; m_cmd = '0; m_a = '0; m_b = '0; m_data = '0; m_nzcv = '0;
    #2;
    do_reset();

    // ADD 5+7 with s=1: response two cycles after acceptance.
    set_req(0, 4'd2, 32'd5, 32'd7, 1'b1);
    #1;
    check("add_r0_ready", 32'(bus.r0_ready), 32'd1);
    step();
    bus.r0_valid = 1'b0;
    step();
    check("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("add_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("add_rsp_data", bus.rsp_data, 32'd12);
    check("add_rsp_nzcv", 32'(bus.rsp_nzcv), 32'd0);
    check("add_status", 32'(bus.status), 32'd0);
    step();

    // Continuous contention with rsp_ready high alternates grants.
    set_req(0, 4'd1, 32'h0F0F_0000, 32'h0000_00F0, 1'b0);
    set_req(1, 4'd5, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    for (int i = 0; i < 9; i++) step();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Carry out of ADD feeds the next ADDC through status.
    set_req(0, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step();
    bus.r0_valid = 1'b0;
    step();
    check("carry_rsp_data", bus.rsp_data, 32'd0);
    check("carry_rsp_nzcv", 32'(bus.rsp_nzcv), 32'b0110);
    check("carry_status", 32'(bus.status), 32'b0110);
    step();
    set_req(1, 4'd3, 32'd0, 32'd0, 1'b0);
    step();
    bus.r1_valid = 1'b0;
    check("addc_c_in", 32'(bus.alu_c_in), 32'd1);
    step();
    check("addc_rsp_data", bus.rsp_data, 32'd1);
    check("addc_status", 32'(bus.status), 32'b0110);
    step();

    // Signed overflow on SUB; s=0 first keeps status, s=1 then takes the flags.
    for (int unsigned k = 0; k < 2; k++) begin
      set_req(1, 4'd4, 32'h8000_0000, 32'd1, (k == 1));
      step();
      bus.r1_valid = 1'b0;
      step();
      check("sub_rsp_data", bus.rsp_data, 32'h7FFF_FFFF);
      check("sub_rsp_v", 32'(bus.rsp_nzcv[0]), 32'd1);
      check("sub_status", 32'(bus.status), (k == 1) ? 32'b0011 : 32'b0110);
      step();
    end

    // Stalled response: no new grants, fields held, then release.
    set_req(0, 4'd2, 32'd100, 32'd23, 1'b0);
    set_req(1, 4'd4, 32'd50, 32'd8, 1'b0);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i >= 2) begin
        check("stall_r0_ready", 32'(bus.r0_ready), 32'd0);
        check("stall_r1_ready", 32'(bus.r1_ready), 32'd0);
      end
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Reset mid-EXEC aborts the operation and restores r0 priority.
    set_req(0, 4'd2, 32'd1, 32'd1, 1'b1);
    set_req(1, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step();
    do_reset();
    check("abort_status", 32'(bus.status), 32'd0);
    set_req(0, 4'd6, 32'd0, 32'h1234_5678, 1'b1);
    set_req(1, 4'd6, 32'd0, 32'h8765_4321, 1'b1);
    #1;
    check("tie_after_rst_r0", 32'(bus.r0_ready), 32'd1);
    check("tie_after_rst_r1", 32'(bus.r1_ready), 32'd0);
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic with occasional stalls, drops and resets.
    for (int i = 0; i < 3000; i++) begin
      bus.r0_valid  = ($urandom_range(0, 99) < 60);
      bus.r1_valid  = ($urandom_range(0, 99) < 60);
      bus.r0_cmd    = 4'($urandom_range(0, 7));
      bus.r1_cmd    = 4'($urandom_range(0, 7));
      bus.r0_a      = pick_operand();
      bus.r0_b      = pick_operand();
      bus.r1_a      = pick_operand();
      bus.r1_b      = pick_operand();
      bus.r0_s      = 1'($urandom_range(0, 1));
      bus.r1_s      = 1'($urandom_range(0, 1));
      bus.rsp_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports r0_valid / r1_valid  input  1  requester 0/1 has an operation pending.
REQ-004 SHALL have ports r0_ready / r1_ready  output  1  operation of requester 0/1 accepted this cycle.
REQ-005 SHALL have ports r0_cmd / r1_cmd  input  4  ALU exec command (same 4-bit encoding as the ALU).
REQ-006 SHALL have ports r0_a, r0_b / r1_a, r1_b  input  32  operands in1, in2.
REQ-007 SHALL have ports r0_s / r1_s  input  1  update status flags with this result.
REQ-008 SHALL have ports alu_cmd  output  4, alu_in1  output  32, alu_in2  output  32, alu_c_in  output  1  drive the shared ALU.
REQ-009 SHALL have ports alu_out  input  32, alu_nzcv  input  4  combinational ALU result and flags.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1  result handshake.
REQ-011 SHALL have ports rsp_id  output  1, rsp_data  output  32, rsp_nzcv  output  4  requester index, result, flags.
REQ-012 SHALL have port status  output  4  architectural NZCV register (bit3 N, bit2 Z, bit1 C, bit0 V).

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one operation in flight.
REQ-014 IDLE: if any rN_valid, grant one requester; assert its rN_ready combinationally that cycle; latch its cmd, a, b, s and index; go EXEC.
REQ-015 rN_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-016 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last; last_grant reset value 1 (r0 wins first tie).
REQ-017 alu_cmd/alu_in1/alu_in2 SHALL be driven continuously from latched cmd/operand registers; alu_c_in SHALL equal status[1].
REQ-018 EXEC (exactly one cycle): capture alu_out -> rsp_data, alu_nzcv -> rsp_nzcv, latched index -> rsp_id; if latched s=1, status <= alu_nzcv, else status unchanged; go RESP.
REQ-019 RESP: rsp_valid=1, rsp_id/data/nzcv stable; on rsp_ready=1 go IDLE; otherwise hold indefinitely.
REQ-020 Latency: accept at edge T -> rsp_valid high from T+2; max throughput one op per 3 cycles with rsp_ready tied high.
REQ-021 Status register passes ALU flags verbatim (logic/move ops with s=1 clear C and V as the ALU reports).
REQ-022 Requester dropping valid before grant SHALL be ignored; no request queued.
REQ-023 New requests SHALL not be granted while RESP stalled.

Reset
REQ-024 rst SHALL immediately force state IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_nzcv=0, status=0000, last_grant=1, latched cmd/operands/s=0.
REQ-025 rst in EXEC or RESP SHALL abort the operation: no response, no status update.

Verification
REQ-026 Reset, r0 ADD(0010) a=5 b=7 s=1 -> r0_ready same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=12, rsp_nzcv=0000, status=0000.
REQ-027 r0 and r1 valid together continuously, rsp_ready=1 -> grants alternate r0, r1, r0; each rsp_id matches; new grant every 3 cycles.
REQ-028 r0 ADD 0xFFFFFFFF+1 s=1 -> rsp_data=0, rsp_nzcv=0110, status=0110; then r1 ADDC(0011) 0+0 s=0 -> alu_c_in=1, rsp_data=1, status stays 0110.
REQ-029 r1 SUB(0100) 0x80000000-1 s=1 -> rsp_data=0x7FFFFFFF, V=1 in rsp_nzcv and status; same op with s=0 leaves status unchanged.
REQ-030 rsp_ready low 5 cycles in RESP with both requesters valid -> rsp fields stable, r0_ready=r1_ready=0; rsp_ready high -> IDLE, next grant following cycle.
REQ-031 rst asserted during EXEC -> no rsp_valid, status=0000, next grant goes to r0 on tie.
